// File: rtl/key_event_arbiter.sv
// Two-channel keyboard event arbiter: per-channel FIFOs with drop counters feeding one
// registered output with round-robin selection when both channels have pending events.
module key_event_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic       keyReadyA,
   input  logic [7:0] savedByteA,
   input  logic       keyReadyB,
   input  logic [7:0] savedByteB,
   input  logic       outReady,
   output logic       outValid,
   output logic [7:0] outByte,
   output logic       outSource,
   output logic [7:0] dropCountA,
   output logic [7:0] dropCountB,
   output logic       busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [7:0]    memA [DEPTH];
   logic [7:0]    memB [DEPTH];
   logic [PW-1:0] wrPtrA, rdPtrA, wrPtrB, rdPtrB;
   logic [CW-1:0] cntA, cntB;
   logic          lastGrant;  // 0 = A, 1 = B

   logic notEmptyA, notEmptyB, fullA, fullB;
   logic loadOut, popA, popB, pushA, pushB, dropA, dropB;
   logic [7:0] headByte;

   always_comb begin
      notEmptyA = (cntA != '0);
      notEmptyB = (cntB != '0);
      fullA     = (cntA == FULL);
      fullB     = (cntB == FULL);
      loadOut   = (!outValid || outReady) && (notEmptyA || notEmptyB);
      // With both pending, serve the channel that was not granted last time.
      popA      = loadOut && notEmptyA && (!notEmptyB || lastGrant);
      popB      = loadOut && notEmptyB && !popA;
      pushA     = keyReadyA && (!fullA || popA);
      pushB     = keyReadyB && (!fullB || popB);
      dropA     = keyReadyA && fullA && !popA;
      dropB     = keyReadyB && fullB && !popB;
      headByte  = popA ? memA[rdPtrA] : memB[rdPtrB];
      busy      = notEmptyA || notEmptyB || outValid;
   end

   // Storage is not reset; occupancy counters alone define validity.
   always_ff @(posedge clk) begin
      if (pushA) memA[wrPtrA] <= savedByteA;
      if (pushB) memB[wrPtrB] <= savedByteB;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wrPtrA     <= '0;
         rdPtrA     <= '0;
         wrPtrB     <= '0;
         rdPtrB     <= '0;
         cntA       <= '0;
         cntB       <= '0;
         lastGrant  <= 1'b1;
         outValid   <= 1'b0;
         outByte    <= 8'h00;
         outSource  <= 1'b0;
         dropCountA <= 8'h00;
         dropCountB <= 8'h00;
      end else begin
         if (pushA) wrPtrA <= wrPtrA + 1'b1;
         if (popA)  rdPtrA <= rdPtrA + 1'b1;
         if (pushB) wrPtrB <= wrPtrB + 1'b1;
         if (popB)  rdPtrB <= rdPtrB + 1'b1;
         cntA <= cntA + CW'(pushA) - CW'(popA);
         cntB <= cntB + CW'(pushB) - CW'(popB);

         if (popA && notEmptyB)      lastGrant <= 1'b0;
         else if (popB && notEmptyA) lastGrant <= 1'b1;

         if (loadOut) begin
            outValid  <= 1'b1;
            outByte   <= headByte;
            outSource <= popB;
         end else if (outReady) begin
            outValid <= 1'b0;
         end

         if (dropA && dropCountA != 8'hFF) dropCountA <= dropCountA + 8'd1;
         if (dropB && dropCountB != 8'hFF) dropCountB <= dropCountB + 8'd1;
      end
   end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed table, spec scenarios, and random
// traffic compared against a queue-based reference model.
module tb_key_event_arbiter;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       nRST;
   logic       keyReadyA, keyReadyB, outReady;
   logic [7:0] savedByteA, savedByteB;
   logic       outValid, outSource, busy;
   logic [7:0] outByte, dropCountA, dropCountB;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] qA[$];
   logic [7:0] qB[$];
   logic       mValid, mSrc, mLast;
   logic [7:0] mByte;
   int         mDropA, mDropB;

   typedef struct {
      logic       kA;
      logic [7:0] bA;
      logic       kB;
      logic [7:0] bB;
      logic       rdy;
      logic       eV;
      logic [7:0] eByte;
      logic       eSrc;
   } vec_t;

   vec_t tbl[10];

   key_event_arbiter #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .nRST       (nRST),
      .keyReadyA  (keyReadyA),
      .savedByteA (savedByteA),
      .keyReadyB  (keyReadyB),
      .savedByteB (savedByteB),
      .outReady   (outReady),
      .outValid   (outValid),
      .outByte    (outByte),
      .outSource  (outSource),
      .dropCountA (dropCountA),
      .dropCountB (dropCountB),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      qA.delete();
      qB.delete();
      mValid = 1'b0;
      mByte  = 8'h00;
      mSrc   = 1'b0;
      mLast  = 1'b1;
      mDropA = 0;
      mDropB = 0;
   endtask

   task automatic modelStep(input logic kA, input logic [7:0] bA, input logic kB,
                            input logic [7:0] bB, input logic rdy);
      logic load, ch;
      load = (!mValid || rdy) && (qA.size() != 0 || qB.size() != 0);
      if (!load && mValid && rdy) mValid = 1'b0;
      if (load) begin
         if (qA.size() != 0 && qB.size() != 0) begin
            ch    = ~mLast;
            mLast = ch;
         end else begin
            ch = (qA.size() == 0);
         end
         mByte  = ch ? qB.pop_front() : qA.pop_front();
         mSrc   = ch;
         mValid = 1'b1;
      end
      // Capacity is judged after the pop, which covers the full push+pop case.
      if (kA) begin
         if (qA.size() < DEPTH) qA.push_back(bA);
         else if (mDropA < 255) mDropA++;
      end
      if (kB) begin
         if (qB.size() < DEPTH) qB.push_back(bB);
         else if (mDropB < 255) mDropB++;
      end
   endtask

   task automatic compareModel();
      chk("outValid", int'(outValid), int'(mValid));
      chk("outByte", int'(outByte), int'(mByte));
      chk("outSource", int'(outSource), int'(mSrc));
      chk("dropCountA", int'(dropCountA), mDropA);
      chk("dropCountB", int'(dropCountB), mDropB);
      chk("busy", int'(busy), int'(qA.size() != 0 || qB.size() != 0 || mValid));
   endtask

   task automatic step(input logic kA, input logic [7:0] bA, input logic kB,
                       input logic [7:0] bB, input logic rdy);
      keyReadyA  = kA;
      savedByteA = bA;
      keyReadyB  = kB;
      savedByteB = bB;
      outReady   = rdy;
      @(posedge clk);
      modelStep(kA, bA, kB, bB, rdy);
      #1;
      compareModel();
   endtask

   task automatic doReset();
      keyReadyA = 1'b0;
      keyReadyB = 1'b0;
      outReady  = 1'b0;
      #2;
      nRST = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nRST = 1'b1;
      modelReset();
   endtask

   initial begin
      logic [7:0] fairExp[6];
      nRST       = 1'b0;
      keyReadyA  = 1'b0;
      keyReadyB  = 1'b0;
      savedByteA = 8'h00;
      savedByteB = 8'h00;
      outReady   = 1'b0;
      modelReset();

      // Single event, hold under backpressure, B-only load, empty push
      tbl[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[3] = '{1'b1, 8'h05, 1'b1, 8'h15, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h15, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 8'h16, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h16, 1'b1};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      fairExp = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};

      repeat (2) @(posedge clk);
      @(negedge clk);
      nRST = 1'b1;
      #1;
      chk("rst_outValid", int'(outValid), 0);
      chk("rst_outByte", int'(outByte), 0);
      chk("rst_outSource", int'(outSource), 0);
      chk("rst_dropA", int'(dropCountA), 0);
      chk("rst_dropB", int'(dropCountB), 0);
      chk("rst_busy", int'(busy), 0);

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].kA, tbl[i].bA, tbl[i].kB, tbl[i].bB, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), int'(outValid), int'(tbl[i].eV));
         if (tbl[i].eV) begin
            chk($sformatf("tbl%0d_byte", i), int'(outByte), int'(tbl[i].eByte));
            chk($sformatf("tbl%0d_src", i), int'(outSource), int'(tbl[i].eSrc));
         end
      end

      // Fairness: alternate once both channels have backlog
      doReset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h01 + i), 1'b1, 8'(8'h11 + i), 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("fair%0d_valid", i), int'(outValid), 1);
         chk($sformatf("fair%0d_byte", i), int'(outByte), int'(fairExp[i]));
         step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      end
      chk("fair_done", int'(outValid), 0);

      // Overflow and saturation
      doReset();
      for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b0);
      chk("ovf_dropA", int'(dropCountA), 2);
      for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0);
      chk("sat_dropA", int'(dropCountA), 255);

      // Backpressure hold, then release
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
         chk("bp_byte", int'(outByte), 8'h80);
         chk("bp_src", int'(outSource), 0);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("bp_next", int'(outByte), 8'h81);

      // Full FIFO with simultaneous push and pop
      doReset();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h25, 1'b0, 8'h00, 1'b1);
      chk("pp_byte", int'(outByte), 8'h21);
      chk("pp_dropA", int'(dropCountA), 0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
         chk($sformatf("pp_drain%0d", i), int'(outByte), 8'h22 + i);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("pp_idle", int'(outValid), 0);

      // Asynchronous reset mid-cycle with both FIFOs holding two entries
      doReset();
      step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0);
      step(1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 8'h00, 1'b0);
      chk("ar_pre_busy", int'(busy), 1);
      keyReadyA  = 1'b1;
      savedByteA = 8'h77;
      #3;
      nRST = 1'b0;
      #1;
      chk("ar_valid", int'(outValid), 0);
      chk("ar_busy", int'(busy), 0);
      modelReset();
      repeat (2) @(posedge clk);
      keyReadyA = 1'b0;
      @(negedge clk);
      nRST = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("ar_idle_valid", int'(outValid), 0);
      chk("ar_idle_busy", int'(busy), 0);

      // Random traffic against the model
      doReset();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 45), 8'($urandom),
              ($urandom_range(0, 99) < 45), 8'($urandom),
              ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 25)));
      end
      for (int i = 0; i < 2 * DEPTH + 2; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("rand_drained", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the entries per channel FIFO; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port keyReadyA, input, 1 bit: one-cycle new-key strobe from the channel A keyboard controller.
REQ-005 SHALL have port savedByteA, input, 8 bits: channel A key byte, valid when keyReadyA=1.
REQ-006 SHALL have port keyReadyB, input, 1 bit: one-cycle new-key strobe from the channel B keyboard controller.
REQ-007 SHALL have port savedByteB, input, 8 bits: channel B key byte, valid when keyReadyB=1.
REQ-008 SHALL have port outReady, input, 1 bit: downstream can accept the output.
REQ-009 SHALL have port outValid, output, 1 bit: the output register holds an event.
REQ-010 SHALL have port outByte, output, 8 bits: the key byte of the held event.
REQ-011 SHALL have port outSource, output, 1 bit: source of the held event, 0 = A, 1 = B.
REQ-012 SHALL have ports dropCountA and dropCountB, output, 8 bits each: count of events lost to a full FIFO, per channel.
REQ-013 SHALL have port busy, output, 1 bit: asserted when either FIFO is non-empty or outValid=1.

Function
REQ-014 Each channel SHALL have an independent DEPTH-entry FIFO with read and write pointers and an occupancy counter of width $clog2(DEPTH)+1.
REQ-015 keyReadyX=1 with the FIFO not full SHALL write savedByteX at that edge; the entry is visible as non-empty in the next cycle.
REQ-016 keyReadyX=1 with the FIFO full and no same-cycle pop of that channel SHALL discard the byte and increment dropCountX.
REQ-017 dropCountX SHALL saturate at 255.
REQ-018 A full FIFO with a same-cycle push and pop on one channel SHALL accept the push; occupancy stays DEPTH and nothing is dropped.
REQ-019 An empty FIFO with a same-cycle push SHALL NOT forward the byte in that cycle; there is no bypass path.
REQ-020 Pointers SHALL wrap modulo DEPTH.
REQ-021 The output register SHALL load when outValid=0, or when outValid=1 and outReady=1 in the same cycle; a load requires at least one non-empty FIFO.
REQ-022 Load selection: if only one FIFO is non-empty, pop that FIFO.
REQ-023 Load selection: if both are non-empty, pop the channel opposite to lastGrant, then update lastGrant to the channel popped.
REQ-024 Load SHALL copy the FIFO head into outByte, set outSource, and set outValid=1.
REQ-025 With outValid=1 and outReady=0, outValid, outByte and outSource SHALL hold stable.
REQ-026 With outValid=1, outReady=1 and both FIFOs empty, outValid SHALL go to 0 at the next edge.
REQ-027 Minimum latency: keyReadyX in cycle N, with the FIFO empty and the output register free, gives outValid=1 in cycle N+2.
REQ-028 Sustained throughput with outReady held at 1 SHALL be one event per cycle.
REQ-029 Events from one channel SHALL leave in arrival order.
REQ-030 outReady SHALL be ignored while outValid=0.
REQ-031 No combinational path from inputs to outputs SHALL exist, except that busy may be derived combinationally from internal state.

Reset
REQ-032 nRST=0 SHALL asynchronously force all pointers, occupancies and output state to reset values regardless of clk.
REQ-033 Reset values: outValid=0, outByte=0x00, outSource=0, dropCountA=0, dropCountB=0, busy=0, lastGrant=B.
REQ-034 Reset SHALL discard all FIFO contents; FIFO storage itself need not be cleared.
REQ-035 keyReady inputs during reset SHALL be ignored.
REQ-036 Reset asserted mid-handshake SHALL lose the held event with no partial output.

Verification
REQ-037 Single event: keyReadyA pulse with savedByteA=0x41, outReady=1, injected in cycle N -> outValid=1, outByte=0x41, outSource=0 in cycle N+2, and outValid=0 in cycle N+3.
REQ-038 Fairness: three A events (0x01..0x03) and three B events (0x11..0x13) queued with outReady=0, then outReady=1 -> output order 0x01, 0x11, 0x02, 0x12, 0x03, 0x13.
REQ-039 Overflow: DEPTH+3 A pulses with outReady=0 -> dropCountA=2, since one event sits in the output register and DEPTH in the FIFO; 300 further pulses -> dropCountA=255.
REQ-040 Backpressure: outReady=0 for 10 cycles with outValid=1 -> outByte and outSource unchanged every cycle; the first outReady=1 -> next event at the following edge.
REQ-041 Full push+pop: FIFO A full, keyReadyA and pop of A in the same cycle -> dropCountA unchanged and the new byte emerges last, in order.
REQ-042 Async reset: nRST low mid-clock-cycle with both FIFOs holding 2 entries -> outValid=0 and busy=0 immediately, without waiting for a clock edge; after release with no input, the outputs stay idle.
